cordic_issue_sched: RTL and testbench

CORDIC_ISSUE_SCHED -- requirements
Module: cordic_issue_sched

---
 rtl/cordic_issue_sched_pkg.sv | 15 +
 rtl/cordic_issue_sched_sync_fifo.sv | 77 +++++++
 rtl/cordic_issue_sched.sv | 139 +++++++++++++
 tb/tb_cordic_issue_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_issue_sched_pkg.sv
// Shared types and defaults for the CORDIC issue scheduler slice.
package pkg_msg;

  localparam int SCHED_FIFO_DEPTH = 8;
  localparam int SCHED_CREDITS    = 8;
  localparam int THETA_W          = 48;
  localparam int CNT_W            = 4;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_STALL = 2'd2
  } sched_state_t;

endpackage

// File: rtl/cordic_issue_sched_sync_fifo.sv
// Synchronous FIFO with flush; head word is visible combinationally on o_data.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign pop_ok  = i_pop && !o_empty && !i_flush;
  assign push_ok = i_push && !i_flush && (!o_full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_empty = (level_q == '0);
  assign o_full  = (level_q == LW'(DEPTH));
  assign o_level = level_q;

endmodule

// File: rtl/cordic_issue_sched.sv
// Queues angle words and issues them to the CORDIC core, one per cycle,
// limited by downstream result-buffer credits and the pipeline enable.
module cordic_issue_sched
  import pkg_msg::*;
#(
  parameter int FIFO_DEPTH = SCHED_FIFO_DEPTH,
  parameter int CREDITS    = SCHED_CREDITS
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [THETA_W-1:0] i_theta,
  input  logic               i_theta_valid,
  input  logic               i_flush,
  input  logic               i_pipeline_en,
  input  logic               i_result_pop,
  output logic               o_cordic_start,
  output logic [THETA_W-1:0] o_cordic_theta,
  output logic [CNT_W-1:0]   o_fifo_level,
  output logic [CNT_W-1:0]   o_credit,
  output logic               o_overflow,
  output logic               o_credit_err,
  output logic               o_busy
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);

  sched_state_t       state_q, state_d;
  logic [CNT_W-1:0]   credit_q, credit_d;
  logic               start_q, start_d;
  logic [THETA_W-1:0] theta_q, theta_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic [THETA_W-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LW-1:0]      fifo_level;

  logic               issue;
  logic               push_req;
  logic               pop_ok;
  logic               drained;

  assign push_req = i_theta_valid && !i_flush;
  assign pop_ok   = i_result_pop && (credit_q != CREDIT_MAX) && !i_flush;
  assign issue    = (state_q != SCHED_STALL) && !fifo_empty && (credit_q != '0)
                    && i_pipeline_en && !i_flush;
  assign drained  = fifo_empty || (issue && (fifo_level == LW'(1)));

  sync_fifo #(
    .WIDTH (THETA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_push  (push_req),
    .i_pop   (issue),
    .i_data  (i_theta),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level)
  );

  // Issue decisions are registered, so the CORDIC sees start/theta one cycle after the pop.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    start_d  = issue;
    theta_d  = issue ? fifo_head : theta_q;
    ovf_d    = push_req && fifo_full && !issue;
    err_d    = i_result_pop && (credit_q == CREDIT_MAX) && !i_flush;

    unique case ({pop_ok, issue})
      2'b10:   credit_d = credit_q + CNT_W'(1);
      2'b01:   credit_d = credit_q - CNT_W'(1);
      default: credit_d = credit_q;
    endcase

    unique case (state_q)
      SCHED_IDLE: begin
        if (!fifo_empty) begin
          state_d = i_pipeline_en ? SCHED_ISSUE : SCHED_STALL;
        end
      end
      SCHED_ISSUE: begin
        if (!i_pipeline_en) begin
          state_d = SCHED_STALL;
        end else if (drained && !push_req) begin
          state_d = SCHED_IDLE;
        end
      end
      SCHED_STALL: begin
        if (i_pipeline_en) begin
          state_d = SCHED_ISSUE;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase

    if (i_flush) begin
      state_d  = SCHED_IDLE;
      credit_d = CREDIT_MAX;
      start_d  = 1'b0;
      theta_d  = '0;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= SCHED_IDLE;
      credit_q <= CREDIT_MAX;
      start_q  <= 1'b0;
      theta_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      start_q  <= start_d;
      theta_q  <= theta_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign o_cordic_start = start_q;
  assign o_cordic_theta = theta_q;
  assign o_fifo_level   = CNT_W'(fifo_level);
  assign o_credit       = credit_q;
  assign o_overflow     = ovf_q;
  assign o_credit_err   = err_q;
  assign o_busy         = !fifo_empty || (credit_q != CREDIT_MAX);

endmodule

// File: tb/tb_cordic_issue_sched.sv
// Directed scenarios plus a randomized run, each cycle checked against a
// queue-based model of the scheduler's issue/credit rules.
module tb_cordic_issue_sched;

  localparam int DEPTH = 8;
  localparam int CRED  = 8;
  localparam int M_IDLE  = 0;
  localparam int M_ISSUE = 1;
  localparam int M_STALL = 2;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [47:0] theta = '0;
  logic        thetaValid = 1'b0;
  logic        flush = 1'b0;
  logic        pipelineEn = 1'b0;
  logic        resultPop = 1'b0;
  logic        cordicStart;
  logic [47:0] cordicTheta;
  logic [3:0]  fifoLevel;
  logic [3:0]  credit;
  logic        overflow;
  logic        creditErr;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  logic [47:0] mq[$];
  int          mCredit = CRED;
  int          mMode = M_IDLE;
  logic        mStart = 1'b0;
  logic [47:0] mTheta = '0;
  logic        mOvf = 1'b0;
  logic        mErr = 1'b0;

  cordic_issue_sched #(
    .FIFO_DEPTH (DEPTH),
    .CREDITS    (CRED)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_theta        (theta),
    .i_theta_valid  (thetaValid),
    .i_flush        (flush),
    .i_pipeline_en  (pipelineEn),
    .i_result_pop   (resultPop),
    .o_cordic_start (cordicStart),
    .o_cordic_theta (cordicTheta),
    .o_fifo_level   (fifoLevel),
    .o_credit       (credit),
    .o_overflow     (overflow),
    .o_credit_err   (creditErr),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic modelStep(input logic push, input logic [47:0] th, input logic fl,
                           input logic en, input logic pop, input logic rn);
    int  sizeBefore;
    bit  canIssue;
    bit  errNow;
    if (!rn || fl) begin
      mq.delete();
      mCredit = CRED;
      mMode   = M_IDLE;
      mStart  = 1'b0;
      mTheta  = '0;
      mOvf    = 1'b0;
      mErr    = 1'b0;
    end else begin
      sizeBefore = mq.size();
      canIssue   = (mMode != M_STALL) && (sizeBefore > 0) && (mCredit > 0) && en;
      errNow     = pop && (mCredit == CRED);
      mErr       = errNow;
      mStart     = canIssue;
      if (canIssue) mTheta = mq.pop_front();
      mCredit = mCredit + ((pop && !errNow) ? 1 : 0) - (canIssue ? 1 : 0);
      mOvf = 1'b0;
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(th);
        else mOvf = 1'b1;
      end
      case (mMode)
        M_IDLE:  if (sizeBefore > 0) mMode = en ? M_ISSUE : M_STALL;
        M_ISSUE: if (!en) mMode = M_STALL; else if (mq.size() == 0) mMode = M_IDLE;
        default: if (en) mMode = M_ISSUE;
      endcase
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] expLevel;
    logic [3:0] expCredit;
    logic       expBusy;
    expLevel  = 4'(mq.size());
    expCredit = 4'(mCredit);
    expBusy   = (mq.size() > 0) || (mCredit != CRED);
    compared++;
    assert (cordicStart === mStart) else begin
      mismatched++;
      $error("[TB] FAIL %s start: observed %b expected %b", tag, cordicStart, mStart);
    end
    compared++;
    assert (cordicTheta === mTheta) else begin
      mismatched++;
      $error("[TB] FAIL %s theta: observed %h expected %h", tag, cordicTheta, mTheta);
    end
    compared++;
    assert (fifoLevel === expLevel) else begin
      mismatched++;
      $error("[TB] FAIL %s level: observed %0d expected %0d", tag, fifoLevel, expLevel);
    end
    compared++;
    assert (credit === expCredit) else begin
      mismatched++;
      $error("[TB] FAIL %s credit: observed %0d expected %0d", tag, credit, expCredit);
    end
    compared++;
    assert (overflow === mOvf) else begin
      mismatched++;
      $error("[TB] FAIL %s overflow: observed %b expected %b", tag, overflow, mOvf);
    end
    compared++;
    assert (creditErr === mErr) else begin
      mismatched++;
      $error("[TB] FAIL %s credit_err: observed %b expected %b", tag, creditErr, mErr);
    end
    compared++;
    assert (busy === expBusy) else begin
      mismatched++;
      $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy, expBusy);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic push, input logic [47:0] th,
                               input logic fl, input logic en, input logic pop, input logic rn);
    thetaValid = push;
    theta      = th;
    flush      = fl;
    pipelineEn = en;
    resultPop  = pop;
    rstN       = rn;
    @(posedge clk);
    modelStep(push, th, fl, en, pop, rn);
    #1;
    checkOutput(tag);
  endtask

  task automatic step(input string tag, input logic push, input logic [47:0] th,
                      input logic fl, input logic en, input logic pop);
    applyStimulus(tag, push, th, fl, en, pop, 1'b1);
  endtask

  initial begin
    logic [47:0] w;
    $display("[TB] start");

    applyStimulus("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    step("single_push", 1'b1, 48'h0000_1234_5678, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("single_wait", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("single_pop", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    step("single_idle", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) step("burst10", 1'b1, 48'hA000_0000_0000 + 48'(i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("burst_stall", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step("burst_pop", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("burst_tail", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step("burst_return", 1'b0, '0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 9; i++) step("stall_push9", 1'b1, 48'hB000_0000_0000 + 48'(i), 1'b0, 1'b0, 1'b0);
    step("stall_hold", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step("stall_release", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step("stall_return", 1'b0, '0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 5; i++) step("flush_fill", 1'b1, 48'hC000_0000_0000 + 48'(i), 1'b0, 1'b1, 1'b0);
    step("flush_fill", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("flush_queue", 1'b1, 48'hC100_0000_0000 + 48'(i), 1'b0, 1'b0, 1'b0);
    step("flush_hit", 1'b1, 48'hDEAD_BEEF_0000, 1'b1, 1'b1, 1'b1);
    step("flush_after", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    step("err_pop", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step("credit4_fill", 1'b1, 48'hE000_0000_0000 + 48'(i), 1'b0, 1'b1, 1'b0);
    step("credit4_fill", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("credit4_push", 1'b1, 48'hE100_0000_0001, 1'b0, 1'b1, 1'b0);
    step("credit4_issue_pop", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step("credit4_return", 1'b0, '0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 4; i++) step("rst_burst", 1'b1, 48'hF000_0000_0000 + 48'(i), 1'b0, 1'b1, 1'b0);
    applyStimulus("rst_mid", 1'b1, 48'hF0F0_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    step("rst_release", 1'b1, 48'hF100_0000_0000, 1'b0, 1'b1, 1'b0);
    step("rst_release2", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("rst_release3", 1'b0, '0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 600; i++) begin
      w = {16'($urandom), 32'($urandom)};
      applyStimulus("random", 1'($urandom_range(0, 99) < 55), w,
                    1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 80),
                    1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 199) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
